// File: rtl/wash_seq_ctrl_if.sv
// Handshake bundle between the wash sequencer and the selection/display logic.
// The master side drives the control pulses; the slave side reports the cycle status.
interface wash_seq_ctrl_if;
    logic       start;
    logic [1:0] mode;
    logic       pause_pos;
    logic       abort;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic [7:0] remain_s;
    logic       paused;
    logic       fine;
    logic [7:0] st_light;

    modport master (
        output start, mode, pause_pos, abort,
        input  busy, done, stage, remain_s, paused, fine, st_light
    );

    modport slave (
        input  start, mode, pause_pos, abort,
        output busy, done, stage, remain_s, paused, fine, st_light
    );
endinterface

// File: rtl/wash_seq_ctrl.sv
// Wash-phase sequencer: FILL -> WASH -> RINSE -> SPIN (or SPIN only for dry mode)
// with per-second countdowns, pause/resume, pause-overtime fine flag and status lights.
module wash_seq_ctrl #(
    parameter int SEC_CYCLES  = 100000000,
    parameter int T_FILL      = 4,
    parameter int T_WASH_S    = 6,
    parameter int T_WASH_M    = 10,
    parameter int T_WASH_B    = 14,
    parameter int T_RINSE     = 6,
    parameter int T_SPIN      = 8,
    parameter int T_DRY       = 12,
    parameter int PAUSE_LIMIT = 20
) (
    input  logic           clk,
    input  logic           rst,
    wash_seq_ctrl_if.slave bus
);
    localparam int PW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4
    } stage_t;

    function automatic logic [5:0] stage_dur(input stage_t s, input logic [1:0] m);
        logic [5:0] r;
        r = 6'd0;
        case (s)
            FILL:  r = 6'(T_FILL);
            WASH: begin
                case (m)
                    2'd0:    r = 6'(T_WASH_S);
                    2'd1:    r = 6'(T_WASH_M);
                    default: r = 6'(T_WASH_B);
                endcase
            end
            RINSE: r = 6'(T_RINSE);
            SPIN:  r = (m == 2'd3) ? 6'(T_DRY) : 6'(T_SPIN);
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Seconds still owed by the stages that follow s in the latched mode.
    function automatic logic [7:0] later_sum(input stage_t s, input logic [1:0] m);
        logic [7:0] r;
        r = 8'd0;
        case (s)
            FILL:  r = 8'(stage_dur(WASH, m)) + 8'(T_RINSE) + 8'(T_SPIN);
            WASH:  r = 8'(T_RINSE) + 8'(T_SPIN);
            RINSE: r = 8'(T_SPIN);
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    function automatic stage_t next_stage(input stage_t s);
        stage_t r;
        case (s)
            FILL:    r = WASH;
            WASH:    r = RINSE;
            RINSE:   r = SPIN;
            default: r = IDLE;
        endcase
        return r;
    endfunction

    stage_t          stage_reg, stage_next;
    logic [1:0]      mode_reg, mode_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [5:0]      cnt_reg, cnt_next;
    logic [7:0]      pause_s_reg, pause_s_next;
    logic            paused_reg, paused_next;
    logic            fine_reg, fine_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            done_latch_reg, done_latch_next;
    logic [7:0]      remain_reg, remain_next;
    logic [7:0]      light_reg, light_next;
    logic [3:0]      stage_hot;
    logic [7:0]      pause_s_inc;
    logic            sec_tick;

    assign sec_tick    = busy_reg && (presc_reg == PW'(SEC_CYCLES - 1));
    assign pause_s_inc = (pause_s_reg == 8'hFF) ? 8'hFF : pause_s_reg + 8'd1;

    always_comb begin
        stage_next      = stage_reg;
        mode_next       = mode_reg;
        presc_next      = presc_reg;
        cnt_next        = cnt_reg;
        pause_s_next    = pause_s_reg;
        paused_next     = paused_reg;
        fine_next       = fine_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        done_latch_next = done_latch_reg;

        if (!busy_reg) begin
            // In IDLE only start matters; a coincident abort is meaningless here.
            if (bus.start) begin
                mode_next       = bus.mode;
                stage_next      = (bus.mode == 2'd3) ? SPIN : FILL;
                cnt_next        = stage_dur(stage_next, bus.mode);
                busy_next       = 1'b1;
                presc_next      = '0;
                pause_s_next    = 8'd0;
                fine_next       = 1'b0;
                paused_next     = 1'b0;
                done_latch_next = 1'b0;
            end
        end else if (bus.abort) begin
            stage_next  = IDLE;
            busy_next   = 1'b0;
            paused_next = 1'b0;
            cnt_next    = 6'd0;
            presc_next  = '0;
        end else begin
            presc_next = sec_tick ? '0 : presc_reg + PW'(1);
            if (sec_tick && paused_reg) begin
                pause_s_next = pause_s_inc;
                if (32'(pause_s_inc) >= PAUSE_LIMIT)
                    fine_next = 1'b1;
            end
            if (bus.pause_pos)
                paused_next = !paused_reg;
            if (sec_tick && !paused_reg) begin
                if (cnt_reg == 6'd1) begin
                    if (stage_reg == SPIN) begin
                        stage_next      = IDLE;
                        busy_next       = 1'b0;
                        done_next       = 1'b1;
                        done_latch_next = 1'b1;
                        paused_next     = 1'b0;
                        cnt_next        = 6'd0;
                        presc_next      = '0;
                    end else begin
                        stage_next = next_stage(stage_reg);
                        cnt_next   = stage_dur(stage_next, mode_reg);
                    end
                end else begin
                    cnt_next = cnt_reg - 6'd1;
                end
            end
        end

        remain_next = busy_next ? (8'(cnt_next) + later_sum(stage_next, mode_next)) : 8'd0;
        light_next  = {fine_next, paused_next, done_latch_next, busy_next, stage_hot};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hot
            assign stage_hot[gi] = (stage_next == stage_t'(3'(gi + 1)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg      <= IDLE;
            mode_reg       <= 2'd0;
            presc_reg      <= '0;
            cnt_reg        <= 6'd0;
            pause_s_reg    <= 8'd0;
            paused_reg     <= 1'b0;
            fine_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            done_latch_reg <= 1'b0;
            remain_reg     <= 8'd0;
            light_reg      <= 8'd0;
        end else begin
            stage_reg      <= stage_next;
            mode_reg       <= mode_next;
            presc_reg      <= presc_next;
            cnt_reg        <= cnt_next;
            pause_s_reg    <= pause_s_next;
            paused_reg     <= paused_next;
            fine_reg       <= fine_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            done_latch_reg <= done_latch_next;
            remain_reg     <= remain_next;
            light_reg      <= light_next;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.stage    = stage_reg;
    assign bus.remain_s = remain_reg;
    assign bus.paused   = paused_reg;
    assign bus.fine     = fine_reg;
    assign bus.st_light = light_reg;
endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Self-checking bench for wash_seq_ctrl: vector table, directed corner sequences and
// random traffic checked every cycle against a queue-based reference model.
module tb_wash_seq_ctrl;
    localparam int SEC = 4;
    localparam int TF = 4, TWS = 6, TWM = 10, TWB = 14, TR = 6, TS = 8, TD = 12, PL = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wash_seq_ctrl_if bus();

    wash_seq_ctrl #(
        .SEC_CYCLES(SEC), .T_FILL(TF), .T_WASH_S(TWS), .T_WASH_M(TWM), .T_WASH_B(TWB),
        .T_RINSE(TR), .T_SPIN(TS), .T_DRY(TD), .PAUSE_LIMIT(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the cycle is a queue of (stage, seconds-left) entries.
    bit m_busy, m_done, m_paused, m_fine, m_dl;
    int m_pause_s, m_phase;
    int m_q[$];
    int m_d[$];

    function automatic int wash_len(input int m);
        if (m == 0) return TWS;
        if (m == 1) return TWM;
        return TWB;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_paused = 0; m_fine = 0; m_dl = 0;
        m_pause_s = 0; m_phase = 0;
        m_q.delete(); m_d.delete();
    endtask

    task automatic model_step(input bit s, input int m, input bit p, input bit a);
        bit tick;
        bit newp;
        m_done = 0;
        if (!m_busy) begin
            if (s) begin
                m_q.delete(); m_d.delete();
                if (m == 3) begin
                    m_q.push_back(4); m_d.push_back(TD);
                end else begin
                    m_q = '{1, 2, 3, 4};
                    m_d = '{TF, wash_len(m), TR, TS};
                end
                m_busy = 1; m_phase = 0; m_paused = 0; m_pause_s = 0; m_fine = 0; m_dl = 0;
            end
        end else if (a) begin
            m_busy = 0; m_paused = 0;
            m_q.delete(); m_d.delete();
        end else begin
            tick = ((m_phase % SEC) == SEC - 1);
            m_phase++;
            if (tick && m_paused) begin
                if (m_pause_s < 255) m_pause_s++;
                if (m_pause_s >= PL) m_fine = 1;
            end
            newp = p ? !m_paused : m_paused;
            if (tick && !m_paused) begin
                m_d[0] = m_d[0] - 1;
                if (m_d[0] == 0) begin
                    void'(m_q.pop_front());
                    void'(m_d.pop_front());
                    if (m_q.size() == 0) begin
                        m_busy = 0; m_done = 1; m_dl = 1; newp = 0;
                    end
                end
            end
            m_paused = newp;
        end
    endtask

    function automatic logic [22:0] model_vec();
        logic [2:0] st;
        int rem;
        logic [7:0] light;
        rem = 0;
        foreach (m_d[i]) rem += m_d[i];
        st = m_busy ? 3'(m_q[0]) : 3'd0;
        light = {m_fine, m_paused, m_dl, m_busy, st == 3'd4, st == 3'd3, st == 3'd2, st == 3'd1};
        return {m_busy, m_done, st, 8'(rem), m_paused, m_fine, light};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {bus.busy, bus.done, bus.stage, bus.remain_s, bus.paused, bus.fine, bus.st_light};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit s, input logic [1:0] m, input bit p, input bit a);
        bus.start = s; bus.mode = m; bus.pause_pos = p; bus.abort = a;
        @(posedge clk);
        model_step(s, int'(m), p, a);
        #1;
        check("cycle_vs_model", 32'(dut_vec()), 32'(model_vec()));
        bus.start = 1'b0; bus.pause_pos = 1'b0; bus.abort = 1'b0;
    endtask

    typedef struct {
        logic       s;
        logic [1:0] m;
        logic       p;
        logic       a;
        logic       busy;
        logic [2:0] stage;
        logic [7:0] rem;
        logic       paused;
        logic [7:0] light;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int t_wash, t_rinse, t_spin, t_done, n_done;
        bit low_seen;

        tbl[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 8'h00};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 8'h00};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0,  1'b0, 8'h00};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd24, 1'b0, 8'h11};
        tbl[4]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 3'd1, 8'd24, 1'b0, 8'h11};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'd1, 8'd24, 1'b1, 8'h51};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd24, 1'b1, 8'h51};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd24, 1'b1, 8'h51};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0,  1'b0, 8'h00};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 3'd4, 8'd12, 1'b0, 8'h18};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 3'd4, 8'd12, 1'b0, 8'h18};

        bus.start = 1'b0; bus.mode = 2'd0; bus.pause_pos = 1'b0; bus.abort = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec()), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].s, tbl[i].m, tbl[i].p, tbl[i].a);
            check($sformatf("vec%0d", i),
                  {13'd0, bus.busy, bus.stage, bus.remain_s, bus.paused, bus.st_light},
                  {13'd0, tbl[i].busy, tbl[i].stage, tbl[i].rem, tbl[i].paused, tbl[i].light});
            $display("vec %0d start=%0d mode=%0d pause=%0d abort=%0d -> busy=%0d stage=%0d remain=%0d light=%h",
                     i, tbl[i].s, tbl[i].m, tbl[i].p, tbl[i].a,
                     bus.busy, bus.stage, bus.remain_s, bus.st_light);
        end
        cyc(0, 2'd0, 0, 1);

        // Full small-load run: stage boundaries and done timing.
        cyc(1, 2'd0, 0, 0);
        check("mode0_remain_start", 32'(bus.remain_s), 32'd24);
        t_wash = -1; t_rinse = -1; t_spin = -1; t_done = -1;
        for (int i = 1; i <= 120 && t_done < 0; i++) begin
            cyc(0, 2'd0, 0, 0);
            if (t_wash < 0 && bus.stage == 3'd2) t_wash = i;
            if (t_rinse < 0 && bus.stage == 3'd3) t_rinse = i;
            if (t_spin < 0 && bus.stage == 3'd4) t_spin = i;
            if (bus.done) begin
                t_done = i;
                check("mode0_done_light", 32'(bus.st_light), 32'h20);
            end
        end
        check("mode0_t_wash", 32'(t_wash), 32'd16);
        check("mode0_t_rinse", 32'(t_rinse), 32'd40);
        check("mode0_t_spin", 32'(t_spin), 32'd64);
        check("mode0_t_done", 32'(t_done), 32'd96);
        $display("run mode0 wash@%0d rinse@%0d spin@%0d done@%0d", t_wash, t_rinse, t_spin, t_done);

        // Dry-only run.
        cyc(1, 2'd3, 0, 0);
        check("dry_remain_start", 32'(bus.remain_s), 32'd12);
        t_done = -1; low_seen = 0;
        for (int i = 1; i <= 60 && t_done < 0; i++) begin
            cyc(0, 2'd3, 0, 0);
            if (bus.stage inside {3'd1, 3'd2, 3'd3}) low_seen = 1;
            if (bus.done) t_done = i;
        end
        check("dry_t_done", 32'(t_done), 32'd48);
        check("dry_no_low_stage", 32'(low_seen), 32'd0);
        $display("run dry done@%0d", t_done);

        // Big load, pause in WASH with counter at 9 for 10 s.
        cyc(1, 2'd2, 0, 0);
        repeat (36) cyc(0, 2'd2, 0, 0);
        check("big_remain_before_pause", 32'(bus.remain_s), 32'd23);
        cyc(0, 2'd2, 1, 0);
        repeat (39) cyc(0, 2'd2, 0, 0);
        check("big_remain_frozen", 32'(bus.remain_s), 32'd23);
        check("big_no_fine", 32'(bus.fine), 32'd0);
        cyc(0, 2'd2, 1, 0);
        t_done = -1;
        for (int i = 0; i < 200 && t_done < 0; i++) begin
            cyc(0, 2'd2, 0, 0);
            if (bus.done) t_done = i;
        end
        check("big_completes", 32'(t_done >= 0), 32'd1);
        $display("run big pause 10s done=%0d", t_done >= 0);

        // Pause coinciding with the last FILL tick; start while busy ignored.
        cyc(1, 2'd1, 0, 0);
        repeat (15) cyc(0, 2'd1, 0, 0);
        cyc(0, 2'd1, 1, 0);
        check("coinc_stage", 32'(bus.stage), 32'd2);
        check("coinc_paused", 32'(bus.paused), 32'd1);
        check("coinc_remain", 32'(bus.remain_s), 32'd24);
        cyc(1, 2'd2, 0, 0);
        check("start_busy_ignored", 32'(bus.remain_s), 32'd24);
        repeat (8) cyc(0, 2'd1, 0, 0);
        check("coinc_held", 32'(bus.remain_s), 32'd24);
        cyc(0, 2'd1, 0, 1);
        $display("run coincident pause stage=%0d remain=%0d", bus.stage, bus.remain_s);

        // Overtime pause in RINSE, then abort keeps fine, new start clears it.
        cyc(1, 2'd0, 0, 0);
        repeat (40) cyc(0, 2'd0, 0, 0);
        check("fine_in_rinse", 32'(bus.stage), 32'd3);
        cyc(0, 2'd0, 1, 0);
        repeat (84) cyc(0, 2'd0, 0, 0);
        check("fine_set", 32'(bus.fine), 32'd1);
        check("fine_light", 32'(bus.st_light[7]), 32'd1);
        cyc(0, 2'd0, 0, 1);
        check("abort_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        check("abort_keeps_fine", 32'(bus.fine), 32'd1);
        cyc(1, 2'd0, 0, 0);
        check("start_clears_fine", 32'(bus.fine), 32'd0);
        $display("run fine/abort fine_after_start=%0d", bus.fine);

        // Asynchronous reset mid-SPIN.
        cyc(0, 2'd0, 0, 1);
        cyc(1, 2'd3, 0, 0);
        repeat (10) cyc(0, 2'd3, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 2'd0, 0, 0);
        check("start_after_reset", {24'd0, bus.stage, bus.remain_s[4:0]}, {24'd0, 3'd1, 5'd24});
        $display("run reset mid-spin then start stage=%0d remain=%0d", bus.stage, bus.remain_s);

        // Random traffic against the model.
        n_done = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 40) == 0, 2'($urandom % 4), ($urandom % 25) == 0, ($urandom % 300) == 0);
            if (m_done) begin
                n_done++;
                $display("rand cycle %0d done pulse #%0d fine=%0d", i, n_done, bus.fine);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
